// File: rtl/olive_servo_pkg.sv
// Shared constants and types for the olive servo frame scheduler.
package olive_servo_pkg;

    typedef logic [15:0] width_t;

    localparam int NUM_CH = 8;

    // Register word addresses
    localparam logic [3:0] ADDR_WIDTH0 = 4'd0;
    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_STATUS = 4'd9;

    // CTRL / STATUS bit positions
    localparam int CTRL_EN_LSB      = 0;
    localparam int CTRL_EN_MSB      = 7;
    localparam int CTRL_IEN_BIT     = 31;
    localparam int STATUS_FRAME_BIT = 0;
    localparam int STATUS_US_LSB    = 16;

    // Saturate a requested pulse width to the configured maximum.
    function automatic width_t clamp_width(input width_t w, input width_t max_w);
        return (w > max_w) ? max_w : w;
    endfunction

endpackage

// File: rtl/olive_servo_tick.sv
// Microsecond prescaler: one-cycle tick every TICK_DIV clocks.
module olive_servo_tick
    import olive_servo_pkg::*;
#(
    parameter int TICK_DIV = 25
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    assign tick = (div_cnt_q == TERM);

    // Next prescaler count: wrap to zero on the terminal value.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    // Prescaler state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end

endmodule

// File: rtl/olive_servo_sched.sv
// Servo frame scheduler: register file, frame-boundary shadow copy,
// microsecond frame counter and one width comparator per channel.
module olive_servo_sched
    import olive_servo_pkg::*;
#(
    parameter int TICK_DIV  = 25,
    parameter int PERIOD_US = 20000,
    parameter int MAX_US    = 2500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic [7:0]  servo_pwm
);

    localparam width_t LAST_US = width_t'(PERIOD_US - 1);
    localparam width_t MAX_W   = width_t'(MAX_US);

    logic        tick;
    logic        wrap;
    width_t      width_q    [NUM_CH];
    width_t      width_d    [NUM_CH];
    width_t      width_sh_q [NUM_CH];
    width_t      width_sh_d [NUM_CH];
    logic [7:0]  en_q, en_d, en_sh_q, en_sh_d;
    logic [7:0]  pwm_q, pwm_d;
    logic        ien_q, ien_d;
    logic        frame_q, frame_d;
    width_t      us_cnt_q, us_cnt_d;
    logic [31:0] readdata_q, readdata_d;
    logic        unused_wdata;

    assign unused_wdata = ^avs_writedata[30:16];

    olive_servo_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign wrap = tick && (us_cnt_q == LAST_US);

    // Frame position counter, advanced once per microsecond tick.
    always_comb begin
        us_cnt_d = us_cnt_q;
        if (tick) us_cnt_d = wrap ? '0 : us_cnt_q + 1'b1;
    end

    // Software-visible registers; a frame wrap beats a same-cycle FRAME clear.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) width_d[i] = width_q[i];
        en_d    = en_q;
        ien_d   = ien_q;
        frame_d = frame_q;
        if (avs_write) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (avs_address == ADDR_WIDTH0 + 4'(i))
                    width_d[i] = clamp_width(avs_writedata[15:0], MAX_W);
            end
            if (avs_address == ADDR_CTRL) begin
                en_d  = avs_writedata[CTRL_EN_MSB:CTRL_EN_LSB];
                ien_d = avs_writedata[CTRL_IEN_BIT];
            end
            if (avs_address == ADDR_STATUS && avs_writedata[STATUS_FRAME_BIT])
                frame_d = 1'b0;
        end
        if (wrap) frame_d = 1'b1;
    end

    // Shadow copies take the pre-write register values, only at a wrap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            width_sh_d[i] = wrap ? width_q[i] : width_sh_q[i];
        en_sh_d = wrap ? en_q : en_sh_q;
    end

    // Read mux; unmapped addresses and idle cycles return zero.
    always_comb begin
        readdata_d = '0;
        if (avs_read) begin
            if (avs_address < ADDR_CTRL) begin
                readdata_d[15:0] = width_q[avs_address[2:0]];
            end else if (avs_address == ADDR_CTRL) begin
                readdata_d[CTRL_EN_MSB:CTRL_EN_LSB] = en_q;
                readdata_d[CTRL_IEN_BIT]            = ien_q;
            end else if (avs_address == ADDR_STATUS) begin
                readdata_d[STATUS_FRAME_BIT]      = frame_q;
                readdata_d[STATUS_US_LSB +: 16]   = us_cnt_q;
            end
        end
    end

    // One comparator per channel against the frame position.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
        assign pwm_d[g] = en_sh_q[g] && (us_cnt_q < width_sh_q[g]);
    end

    // All state registers of the scheduler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                width_q[i]    <= '0;
                width_sh_q[i] <= '0;
            end
            en_q       <= '0;
            en_sh_q    <= '0;
            ien_q      <= 1'b0;
            frame_q    <= 1'b0;
            us_cnt_q   <= '0;
            pwm_q      <= '0;
            readdata_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                width_q[i]    <= width_d[i];
                width_sh_q[i] <= width_sh_d[i];
            end
            en_q       <= en_d;
            en_sh_q    <= en_sh_d;
            ien_q      <= ien_d;
            frame_q    <= frame_d;
            us_cnt_q   <= us_cnt_d;
            pwm_q      <= pwm_d;
            readdata_q <= readdata_d;
        end
    end

    assign servo_pwm    = pwm_q;
    assign avs_readdata = readdata_q;
    assign irq          = frame_q & ien_q;

endmodule
